// File: rtl/rob_buffer_if.sv
// Dispatch, writeback, lookup, commit and flush signals of the reorder buffer.
// The pipeline side drives the master modport; rob_buffer takes the slave modport.
interface rob_buffer_if #(
  parameter int unsigned ROB_ADDR_W = 4,
  parameter int unsigned INFO_W     = 128,
  parameter int unsigned DATA_W     = 32
);
  logic                  flush;
  logic                  rob_can_write;
  logic [ROB_ADDR_W-1:0] rob_write_addr;
  logic                  rob_write_en;
  logic                  reg_write_en_in;
  logic [4:0]            reg_write_addr_in;
  logic [INFO_W-1:0]     info_in;
  logic                  wb_en;
  logic [ROB_ADDR_W-1:0] wb_id;
  logic [DATA_W-1:0]     wb_data;
  logic [ROB_ADDR_W-1:0] lookup_id_1;
  logic [ROB_ADDR_W-1:0] lookup_id_2;
  logic                  lookup_done_1;
  logic                  lookup_done_2;
  logic [DATA_W-1:0]     lookup_data_1;
  logic [DATA_W-1:0]     lookup_data_2;
  logic                  commit_valid;
  logic                  commit_ready;
  logic [ROB_ADDR_W-1:0] commit_id;
  logic                  commit_reg_write_en;
  logic [4:0]            commit_reg_write_addr;
  logic [DATA_W-1:0]     commit_data;
  logic [INFO_W-1:0]     commit_info;
  logic                  empty;

  modport slave (
    input  flush, rob_write_en, reg_write_en_in, reg_write_addr_in, info_in,
           wb_en, wb_id, wb_data, lookup_id_1, lookup_id_2, commit_ready,
    output rob_can_write, rob_write_addr, lookup_done_1, lookup_done_2,
           lookup_data_1, lookup_data_2, commit_valid, commit_id,
           commit_reg_write_en, commit_reg_write_addr, commit_data, commit_info, empty
  );

  modport master (
    output flush, rob_write_en, reg_write_en_in, reg_write_addr_in, info_in,
           wb_en, wb_id, wb_data, lookup_id_1, lookup_id_2, commit_ready,
    input  rob_can_write, rob_write_addr, lookup_done_1, lookup_done_2,
           lookup_data_1, lookup_data_2, commit_valid, commit_id,
           commit_reg_write_en, commit_reg_write_addr, commit_data, commit_info, empty
  );
endinterface

// File: rtl/rob_buffer.sv
// Reorder buffer: in-order dispatch at the tail, out-of-order writeback,
// in-order commit from the head, two bypassed operand lookup ports.
module rob_buffer #(
  parameter int unsigned ROB_ADDR_W = 4,
  parameter int unsigned INFO_W     = 128,
  parameter int unsigned DATA_W     = 32
) (
  input logic         clk,
  input logic         rst,
  rob_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ROB_ADDR_W;
  localparam int unsigned PTR_W = ROB_ADDR_W + 1;

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_done;
  logic [DEPTH-1:0]      r_rwe;
  logic [4:0]            r_rwa  [DEPTH];
  logic [DATA_W-1:0]     r_data [DEPTH];
  logic [INFO_W-1:0]     r_info [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;

  logic [ROB_ADDR_W-1:0] w_head_idx;
  logic [ROB_ADDR_W-1:0] w_tail_idx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_wb;
  logic                  w_commit_valid;
  logic                  w_commit;

  // Pointers carry an extra wrap bit to tell full from empty.
  assign w_head_idx     = r_head[ROB_ADDR_W-1:0];
  assign w_tail_idx     = r_tail[ROB_ADDR_W-1:0];
  assign w_full         = (w_head_idx == w_tail_idx) && (r_head[ROB_ADDR_W] != r_tail[ROB_ADDR_W]);
  assign w_empty        = (r_head == r_tail);
  assign w_wr           = bus.rob_write_en && !w_full;
  assign w_wb           = bus.wb_en && r_valid[bus.wb_id];
  assign w_commit_valid = r_valid[w_head_idx] && r_done[w_head_idx];
  assign w_commit       = w_commit_valid && bus.commit_ready;

  // Control state; flush wins over dispatch, writeback and commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + PTR_W'(1);
      end
      if (w_wb) begin
        r_done[bus.wb_id] <= 1'b1;
      end
      if (w_wr) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + PTR_W'(1);
      end
    end
  end

  // Payload storage is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_rwe[w_tail_idx]  <= bus.reg_write_en_in;
      r_rwa[w_tail_idx]  <= bus.reg_write_addr_in;
      r_info[w_tail_idx] <= bus.info_in;
    end
    if (w_wb) begin
      r_data[bus.wb_id] <= bus.wb_data;
    end
  end

  assign bus.rob_can_write  = !w_full;
  assign bus.rob_write_addr = w_tail_idx;
  assign bus.empty          = w_empty;

  assign bus.commit_valid          = w_commit_valid;
  assign bus.commit_id             = w_head_idx;
  assign bus.commit_reg_write_en   = r_rwe[w_head_idx];
  assign bus.commit_reg_write_addr = r_rwa[w_head_idx];
  assign bus.commit_data           = r_data[w_head_idx];
  assign bus.commit_info           = r_info[w_head_idx];

  // w_wb already implies the written entry is valid, so a hit is a live result.
  assign bus.lookup_done_1 = (w_wb && (bus.wb_id == bus.lookup_id_1)) ||
                             (r_valid[bus.lookup_id_1] && r_done[bus.lookup_id_1]);
  assign bus.lookup_data_1 = (w_wb && (bus.wb_id == bus.lookup_id_1)) ? bus.wb_data
                                                                       : r_data[bus.lookup_id_1];
  assign bus.lookup_done_2 = (w_wb && (bus.wb_id == bus.lookup_id_2)) ||
                             (r_valid[bus.lookup_id_2] && r_done[bus.lookup_id_2]);
  assign bus.lookup_data_2 = (w_wb && (bus.wb_id == bus.lookup_id_2)) ? bus.wb_data
                                                                       : r_data[bus.lookup_id_2];
endmodule
